// File: rtl/wb_stage_pkg.sv
//==============================================================================
// Module      : wb_stage_pkg
// Description : Shared bus widths, field offsets, FSM states and exception
//               codes for the write-back stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package wb_stage_pkg;

    localparam int C_CTRL_W = 104;
    localparam int C_CSR_W  = 79;
    localparam int C_EXCP_W = 8;
    localparam int C_CNT_W  = 64;

    // MEM->WB ctrl bus field positions
    localparam int C_CTRL_BREAK   = 103;
    localparam int C_CTRL_IVALID  = 102;
    localparam int C_CTRL_WIDX_HI = 101;
    localparam int C_CTRL_WIDX_LO = 97;
    localparam int C_CTRL_WEN     = 96;
    localparam int C_CTRL_INST_HI = 95;
    localparam int C_CTRL_INST_LO = 64;
    localparam int C_CTRL_PC_HI   = 63;
    localparam int C_CTRL_PC_LO   = 32;
    localparam int C_CTRL_RES_HI  = 31;
    localparam int C_CTRL_RES_LO  = 0;

    // CSR bus field positions
    localparam int C_CSR_WE      = 78;
    localparam int C_CSR_ADDR_HI = 77;
    localparam int C_CSR_ADDR_LO = 64;
    localparam int C_CSR_MASK_HI = 63;
    localparam int C_CSR_MASK_LO = 32;
    localparam int C_CSR_DATA_HI = 31;
    localparam int C_CSR_DATA_LO = 0;

    // Exception bus field positions
    localparam int C_EXCP_ERTN     = 7;
    localparam int C_EXCP_ECODE_HI = 6;
    localparam int C_EXCP_ECODE_LO = 1;
    localparam int C_EXCP_VALID    = 0;

    localparam logic [5:0] C_ECODE_INT = 6'h00;
    localparam logic [5:0] C_ECODE_ADE = 6'h08;
    localparam logic [5:0] C_ECODE_ALE = 6'h09;
    localparam logic [5:0] C_ECODE_SYS = 6'h0b;
    localparam logic [5:0] C_ECODE_BRK = 6'h0c;
    localparam logic [5:0] C_ECODE_INE = 6'h0d;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_trace_reg.sv
//==============================================================================
// Module      : wb_trace_reg
// Description : Registers the difftest/debug trace one cycle after commit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_trace_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit,
    input  logic [31:0] pc,
    input  logic        rf_we,
    input  logic [4:0]  rf_wnum,
    input  logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debug_wb_pc       <= '0;
            debug_wb_rf_we    <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else if (commit) begin
            debug_wb_pc       <= pc;
            debug_wb_rf_we    <= {4{rf_we}};
            debug_wb_rf_wnum  <= rf_wnum;
            debug_wb_rf_wdata <= rf_wdata;
        end else begin
            debug_wb_pc       <= '0;
            debug_wb_rf_we    <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
//==============================================================================
// Module      : wb_stage
// Description : Write-back stage: commits RF/CSR writes, raises exception and
//               ERTN flush, halts on BREAK, counts retired instructions.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int CTRL_W = C_CTRL_W,
    parameter int CSR_W  = C_CSR_W,
    parameter int EXCP_W = C_EXCP_W,
    parameter int CNT_W  = C_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] wb_ctrl_bus,
    input  logic [CSR_W-1:0]  wb_csr_bus,
    input  logic [EXCP_W-1:0] mem_excp_bus,
    input  logic              left_valid,
    output logic              left_ready,
    output logic              fire,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              csr_we,
    output logic [13:0]       csr_addr,
    output logic [31:0]       csr_wmask,
    output logic [31:0]       csr_wdata,
    output logic              excp_flush,
    output logic              excp_ertn,
    output logic [5:0]        excp_ecode,
    output logic [31:0]       excp_pc,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
);

    wb_state_e   r_state;
    wb_state_e   w_state_nxt;

    logic        w_is_break;
    logic        w_inst_valid;
    logic [4:0]  w_widx;
    logic        w_wen;
    logic [31:0] w_pc;
    logic [31:0] w_result;
    logic        w_excp_valid;
    logic        w_ertn;
    logic        w_commit;
    logic        w_excp_commit;
    logic        w_unused_inst;

    assign w_is_break    = wb_ctrl_bus[C_CTRL_BREAK];
    assign w_inst_valid  = wb_ctrl_bus[C_CTRL_IVALID];
    assign w_widx        = wb_ctrl_bus[C_CTRL_WIDX_HI:C_CTRL_WIDX_LO];
    assign w_wen         = wb_ctrl_bus[C_CTRL_WEN];
    assign w_pc          = wb_ctrl_bus[C_CTRL_PC_HI:C_CTRL_PC_LO];
    assign w_result      = wb_ctrl_bus[C_CTRL_RES_HI:C_CTRL_RES_LO];
    assign w_excp_valid  = mem_excp_bus[C_EXCP_VALID];
    assign w_ertn        = mem_excp_bus[C_EXCP_ERTN];
    assign w_unused_inst = ^wb_ctrl_bus[C_CTRL_INST_HI:C_CTRL_INST_LO];

    // Ready drops with reset so nothing is accepted or written while it is held.
    assign left_ready    = !reset && (r_state != ST_HALT);
    assign fire          = left_valid && left_ready;
    // The FLUSH cycle drains whatever MEM presents without committing it.
    assign w_commit      = fire && w_inst_valid && (r_state == ST_RUN);
    assign w_excp_commit = w_commit && (w_excp_valid || w_ertn);

    assign rf_we     = w_commit && w_wen && (w_widx != 5'd0) && !w_excp_valid && !w_ertn;
    assign rf_waddr  = rf_we ? w_widx   : 5'd0;
    assign rf_wdata  = rf_we ? w_result : 32'd0;

    assign csr_we    = w_commit && wb_csr_bus[C_CSR_WE] && !w_excp_valid;
    assign csr_addr  = csr_we ? wb_csr_bus[C_CSR_ADDR_HI:C_CSR_ADDR_LO] : 14'd0;
    assign csr_wmask = csr_we ? wb_csr_bus[C_CSR_MASK_HI:C_CSR_MASK_LO] : 32'd0;
    assign csr_wdata = csr_we ? wb_csr_bus[C_CSR_DATA_HI:C_CSR_DATA_LO] : 32'd0;

    assign halted    = (r_state == ST_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An exception outranks BREAK when both arrive on the same instruction.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (w_excp_commit) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_commit && w_is_break) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_FLUSH: w_state_nxt = ST_RUN;
            ST_HALT:  w_state_nxt = ST_HALT;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            excp_flush <= 1'b0;
            excp_ertn  <= 1'b0;
            excp_ecode <= '0;
            excp_pc    <= '0;
        end else begin
            excp_flush <= w_excp_commit;
            excp_ertn  <= w_excp_commit && w_ertn;
            excp_ecode <= w_excp_commit ? mem_excp_bus[C_EXCP_ECODE_HI:C_EXCP_ECODE_LO] : 6'd0;
            excp_pc    <= w_excp_commit ? w_pc : 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (w_commit) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

    wb_trace_reg u_trace (
        .clk               (clk),
        .reset             (reset),
        .commit            (w_commit),
        .pc                (w_pc),
        .rf_we             (rf_we),
        .rf_wnum           (rf_waddr),
        .rf_wdata          (rf_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
//==============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage with a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wb_stage;
    import wb_stage_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic [103:0]  wb_ctrl_bus;
    logic [78:0]   wb_csr_bus;
    logic [7:0]    mem_excp_bus;
    logic          left_valid;
    logic          left_ready, fire, rf_we, csr_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata, csr_wmask, csr_wdata;
    logic [13:0]   csr_addr;
    logic          excp_flush, excp_ertn, halted;
    logic [5:0]    excp_ecode;
    logic [31:0]   excp_pc;
    logic [63:0]   retire_cnt;
    logic [31:0]   debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]    debug_wb_rf_we;
    logic [4:0]    debug_wb_rf_wnum;

    wb_stage dut (
        .clk(clk), .reset(reset), .wb_ctrl_bus(wb_ctrl_bus), .wb_csr_bus(wb_csr_bus),
        .mem_excp_bus(mem_excp_bus), .left_valid(left_valid), .left_ready(left_ready),
        .fire(fire), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
        .excp_flush(excp_flush), .excp_ertn(excp_ertn), .excp_ecode(excp_ecode),
        .excp_pc(excp_pc), .halted(halted), .retire_cnt(retire_cnt),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a pipeline that is either free, halted, or owes one drain cycle
    bit          m_halted;
    bit          m_draining;
    logic [63:0] m_cnt;
    bit          m_flush;
    bit          m_ertn;
    logic [5:0]  m_ecode;
    logic [31:0] m_epc;
    logic [31:0] m_tr_pc, m_tr_wdata;
    logic [3:0]  m_tr_we;
    logic [4:0]  m_tr_wnum;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [103:0] mk_ctrl(input bit brk, input bit iv, input logic [4:0] idx,
                                             input bit en, input logic [31:0] pc,
                                             input logic [31:0] res);
        return {brk, iv, idx, en, 32'h0000_0013, pc, res};
    endfunction

    task automatic model_reset();
        m_halted = 0; m_draining = 0; m_cnt = '0; m_flush = 0; m_ertn = 0;
        m_ecode = '0; m_epc = '0; m_tr_pc = '0; m_tr_we = '0; m_tr_wnum = '0; m_tr_wdata = '0;
    endtask

    task automatic check_regs();
        chk("excp_flush", excp_flush, m_flush);
        if (m_flush) begin
            chk("excp_ertn", excp_ertn, m_ertn);
            chk("excp_ecode", excp_ecode, m_ecode);
            chk("excp_pc", excp_pc, m_epc);
        end
        chk("halted", halted, m_halted);
        chk("retire_cnt", retire_cnt, m_cnt);
        chk("dbg_pc", debug_wb_pc, m_tr_pc);
        chk("dbg_we", debug_wb_rf_we, m_tr_we);
        chk("dbg_wnum", debug_wb_rf_wnum, m_tr_wnum);
        chk("dbg_wdata", debug_wb_rf_wdata, m_tr_wdata);
    endtask

    // One clock: drive, check combinational outputs, clock, check registered outputs
    task automatic step(input logic [103:0] ctrl, input logic [78:0] csr,
                        input logic [7:0] excp, input bit valid);
        bit iv, exc, e_fire, e_commit, e_rfwe, e_csrwe;
        @(negedge clk);
        wb_ctrl_bus = ctrl; wb_csr_bus = csr; mem_excp_bus = excp; left_valid = valid;
        #1;
        iv       = ctrl[102];
        exc      = excp[0] | excp[7];
        e_fire   = valid && !m_halted;
        e_commit = e_fire && iv && !m_draining;
        e_rfwe   = e_commit && ctrl[96] && (ctrl[101:97] != 5'd0) && !exc;
        e_csrwe  = e_commit && csr[78] && !excp[0];
        chk("left_ready", left_ready, !m_halted);
        chk("fire", fire, e_fire);
        chk("rf_we", rf_we, e_rfwe);
        if (e_rfwe) begin
            chk("rf_waddr", rf_waddr, ctrl[101:97]);
            chk("rf_wdata", rf_wdata, ctrl[31:0]);
        end
        chk("csr_we", csr_we, e_csrwe);
        if (e_csrwe) begin
            chk("csr_addr", csr_addr, csr[77:64]);
            chk("csr_wmask", csr_wmask, csr[63:32]);
            chk("csr_wdata", csr_wdata, csr[31:0]);
        end
        @(posedge clk);
        #1;
        m_flush    = e_commit && exc;
        m_ertn     = excp[7];
        m_ecode    = excp[6:1];
        m_epc      = ctrl[63:32];
        m_draining = m_flush;
        if (e_commit && !exc && ctrl[103]) m_halted = 1;
        if (e_commit) m_cnt = m_cnt + 64'd1;
        m_tr_pc    = e_commit ? ctrl[63:32] : 32'd0;
        m_tr_we    = e_rfwe ? 4'hf : 4'h0;
        m_tr_wnum  = e_rfwe ? ctrl[101:97] : 5'd0;
        m_tr_wdata = e_rfwe ? ctrl[31:0] : 32'd0;
        check_regs();
    endtask

    // Asserts reset right now (asynchronously), checks everything is quiet, then releases
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_ready", left_ready, 1'b0);
        chk("rst_fire", fire, 1'b0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_csr_we", csr_we, 1'b0);
        chk("rst_csr_wdata", csr_wdata, 32'd0);
        check_regs();
        left_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_ready", left_ready, 1'b1);
    endtask

    function automatic logic [103:0] rnd_ctrl(input int brk_pct);
        return mk_ctrl($urandom_range(99) < brk_pct, $urandom_range(99) < 85,
                       5'($urandom_range(31)), 1'($urandom), $urandom, $urandom);
    endfunction

    function automatic logic [7:0] rnd_excp();
        logic [7:0] e;
        e = '0;
        e[6:1] = 6'($urandom_range(63));
        e[0] = $urandom_range(99) < 10;
        e[7] = $urandom_range(99) < 5;
        return e;
    endfunction

    initial begin
        reset = 1'b1; left_valid = 1'b1;
        wb_ctrl_bus = mk_ctrl(0, 1, 5'd3, 1, 32'h1c00_0000, 32'hdead_beef);
        wb_csr_bus = {1'b1, 14'h1, 32'hffff_ffff, 32'h5};
        mem_excp_bus = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        do_reset();

        // Plain add writing r5
        step(mk_ctrl(0, 1, 5'd5, 1, 32'h1c00_0000, 32'h1234), 79'd0, 8'h00, 1);
        chk("add_cnt", retire_cnt, 64'd1);
        chk("add_trace_we", debug_wb_rf_we, 4'hf);
        // r0 destination is counted but not written; bubble is not counted
        step(mk_ctrl(0, 1, 5'd0, 1, 32'h1c00_0004, 32'h55), 79'd0, 8'h00, 1);
        step(mk_ctrl(0, 0, 5'd7, 1, 32'h1c00_0008, 32'h66), 79'd0, 8'h00, 1);
        chk("bubble_cnt", retire_cnt, 64'd2);
        // CSR write alongside RF write, then ERTN that may still write CSR
        step(mk_ctrl(0, 1, 5'd9, 1, 32'h1c00_000c, 32'h77), {1'b1, 14'h0006, 32'h0000_00ff, 32'habcd},
             8'h00, 1);
        step(mk_ctrl(0, 1, 5'd9, 1, 32'h1c00_0010, 32'h88), {1'b1, 14'h0000, 32'h0000_0007, 32'h3},
             8'h80, 1);
        chk("ertn_flag", excp_ertn, 1'b1);
        step(mk_ctrl(0, 0, 5'd0, 0, 32'h0, 32'h0), 79'd0, 8'h00, 0);

        // Syscall exception followed by a younger instruction that must be drained
        step(mk_ctrl(0, 1, 5'd4, 1, 32'h1c00_0100, 32'h99), {1'b1, 14'h5, 32'h1, 32'h1},
             {1'b0, C_ECODE_SYS, 1'b1}, 1);
        chk("sys_flush", excp_flush, 1'b1);
        chk("sys_ecode", excp_ecode, 6'h0b);
        chk("sys_pc", excp_pc, 32'h1c00_0100);
        step(mk_ctrl(0, 1, 5'd6, 1, 32'h1c00_0104, 32'haa), 79'd0, 8'h00, 1);
        chk("drain_flush_gone", excp_flush, 1'b0);
        chk("drain_not_traced", debug_wb_pc, 32'd0);

        // BREAK halts; nothing is accepted afterwards
        step(mk_ctrl(1, 1, 5'd2, 1, 32'h1c00_0200, 32'hbb), 79'd0, 8'h00, 1);
        chk("brk_halted", halted, 1'b1);
        repeat (3) step(mk_ctrl(0, 1, 5'd2, 1, 32'h1c00_0204, 32'hcc), 79'd0, 8'h00, 1);
        do_reset();
        // BREAK together with an exception flushes instead of halting
        step(mk_ctrl(1, 1, 5'd2, 1, 32'h1c00_0300, 32'hdd), 79'd0, {1'b0, C_ECODE_BRK, 1'b1}, 1);
        chk("brk_excp_halted", halted, 1'b0);
        chk("brk_excp_flush", excp_flush, 1'b1);
        // Async reset in the middle of the flush pulse
        #2;
        do_reset();

        // Counter wrap
        step(mk_ctrl(0, 0, 5'd0, 0, 32'h0, 32'h0), 79'd0, 8'h00, 0);
        force dut.retire_cnt = 64'hffff_ffff_ffff_ffff;
        #1;
        release dut.retire_cnt;
        m_cnt = 64'hffff_ffff_ffff_ffff;
        step(mk_ctrl(0, 1, 5'd1, 1, 32'h1c00_0400, 32'h1), 79'd0, 8'h00, 1);
        chk("wrap_cnt", retire_cnt, 64'd0);

        // Randomized traffic; leave halt through reset
        for (int i = 0; i < 400; i++) begin
            step(rnd_ctrl(3), {1'($urandom), 14'($urandom), 32'($urandom), 32'($urandom)},
                 rnd_excp(), $urandom_range(99) < 75);
            if (m_halted && $urandom_range(3) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
